// File: rtl/phy_pkg.sv
// Shared lane-level constants and the receive FSM state encoding.
// The serializer imports the same COM constant so both ends agree on the idle/alignment symbol.
package phy_pkg;

  localparam int          SYM_WIDTH         = 8;
  localparam logic [7:0]  COM_SYMBOL        = 8'hBC;
  localparam int          COM_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } lane_state_t;

endpackage

// File: rtl/com_detector.sv
// Serial shift register plus a comparison of the would-be next symbol against COM.
// nxt includes the bit being sampled now, so a match is seen on the edge that takes the symbol's LSB.
module com_detector #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_SYMBOL = 8'hBC
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] nxt,
  output logic             com_match
);

  logic [WIDTH-1:0] sr;

  assign nxt       = {sr[WIDTH-2:0], data_in};
  assign com_match = (nxt == COM_SYMBOL);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= nxt;
    end
  end

endmodule

// File: rtl/serial_parallel.sv
// Lane deserializer: hunts for COM, confirms alignment over a run of COMs, then emits payload bytes.
// Outputs are registered and change on the edge that samples a symbol's LSB.
module serial_parallel #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_SYMBOL = 8'hBC,
  parameter int               COM_COUNT  = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             byte_strobe,
  output logic             active
);

  import phy_pkg::*;

  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(COM_COUNT + 1);

  localparam logic [CW-1:0]    BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] COM_LAST = CNT_W'(COM_COUNT - 1);

  lane_state_t      state;
  logic [CW-1:0]    bit_cnt;
  logic [CNT_W-1:0] com_cnt;
  logic [WIDTH-1:0] nxt;
  logic             com_match;
  logic             at_boundary;

  com_detector #(
    .WIDTH      (WIDTH),
    .COM_SYMBOL (COM_SYMBOL)
  ) u_com_detector (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .nxt       (nxt),
    .com_match (com_match)
  );

  assign at_boundary = (bit_cnt == BIT_LAST);

  // valid_out is a level held for a whole symbol; byte_strobe marks the single
  // cycle on which a consumer should take data_out when valid_out is high.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      bit_cnt     <= at_boundary ? '0 : bit_cnt + 1'b1;

      case (state)
        SEARCH: begin
          // Any bit position may start a symbol here; a match realigns the counter.
          if (com_match) begin
            bit_cnt <= '0;
            com_cnt <= CNT_W'(1);
            if (COM_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end

        ALIGN: begin
          if (at_boundary) begin
            byte_strobe <= 1'b1;
            if (com_match) begin
              com_cnt <= com_cnt + 1'b1;
              if (com_cnt == COM_LAST) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              com_cnt <= '0;
              state   <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          // No loss-of-lock exit; only reset leaves this state.
          if (at_boundary) begin
            byte_strobe <= 1'b1;
            if (com_match) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= nxt;
              valid_out <= 1'b1;
            end
          end
        end

        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parallel.sv
// Bench for serial_parallel: directed lane scenarios plus random payload, checked against a
// bit-history reference model that tracks alignment by symbol position arithmetic.
module tb_serial_parallel;

  localparam int         W   = 8;
  localparam logic [7:0] COM = 8'hBC;
  localparam int         NCOM = 4;

  logic         clk_32f = 1'b0;
  logic         reset   = 1'b0;
  logic         data_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         byte_strobe;
  logic         active;

  serial_parallel #(
    .WIDTH      (W),
    .COM_SYMBOL (COM),
    .COM_COUNT  (NCOM)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  // Clock / reset block
  always #5 clk_32f = ~clk_32f;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: bit history since reset, lock mode and the index of the first aligned COM.
  logic     hist[$];
  int       m_mode;    // 0 hunting, 1 confirming, 2 locked
  int       m_anchor;
  int       m_idx;
  int       m_coms;
  logic [7:0] exp_data;
  logic     exp_valid;
  logic     exp_strobe;
  logic     exp_active;
  logic [W-1:0] exp_q[$];

  int       strobe_seen;
  logic     valid_seen;

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_anchor = 0; m_idx = 0; m_coms = 0;
    exp_data = '0; exp_valid = 1'b0; exp_strobe = 1'b0; exp_active = 1'b0;
  endtask

  task automatic model_step(input logic b);
    logic [7:0] win;
    logic       boundary;
    hist.push_back(b);
    if (hist.size() > W) void'(hist.pop_front());
    win = '0;
    foreach (hist[k]) win = {win[6:0], hist[k]};
    boundary = (m_mode != 0) && (m_idx != m_anchor) && (((m_idx - m_anchor) % W) == 0);
    exp_strobe = boundary;
    if (m_mode == 0) begin
      if (win == COM) begin
        m_anchor = m_idx;
        m_coms   = 1;
        m_mode   = (NCOM == 1) ? 2 : 1;
      end
    end else if (boundary) begin
      if (m_mode == 1) begin
        if (win == COM) begin
          m_coms++;
          if (m_coms == NCOM) m_mode = 2;
        end else begin
          m_coms = 0;
          m_mode = 0;
        end
      end else begin
        if (win != COM) begin
          exp_data  = win;
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
        end
      end
    end
    exp_active = (m_mode == 2);
    m_idx++;
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
    model_step(b);
    if (byte_strobe) strobe_seen++;
    if (valid_out) valid_seen = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = W - 1; i >= W - n; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    strobe_seen = 0;
    send_bits(v, W);
  endtask

  task automatic release_reset();
    @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge clk_32f);
    #3;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_32f);
    release_reset();
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_32f);
      data_in = i[0];
    end
    @(posedge clk_32f); #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", byte_strobe); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    release_reset();
  endtask

  task automatic test_align();
    valid_seen = 1'b0;
    repeat (3) send_byte(COM);
    checks++; if (active !== 1'b0 || exp_active !== 1'b0) begin errors++; $display("FAIL align_after3 got=%b exp=0", active); end
    strobe_seen = 0;
    send_bits(COM, 7);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL align_before_lsb got=%b exp=0", active); end
    send_bit(COM[0]);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL align_on_lsb got=%b exp=1", active); end
    checks++; if (byte_strobe !== 1'b1) begin errors++; $display("FAIL align_strobe got=%b exp=1", byte_strobe); end
    checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL align_valid got=%b exp=0", valid_seen); end
  endtask

  task automatic test_payload();
    logic [7:0] exp;
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    foreach (exp_q[k]) begin
      send_byte(exp_q[k]);
      exp = exp_q[k];
      checks++; if (data_out !== exp) begin errors++; $display("FAIL payload_data got=%h exp=%h", data_out, exp); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL payload_valid got=%b exp=1", valid_out); end
      checks++; if (strobe_seen != 1) begin errors++; $display("FAIL payload_strobes got=%0d exp=1", strobe_seen); end
      checks++; if (data_out !== exp_data) begin errors++; $display("FAIL payload_model got=%h exp=%h", data_out, exp_data); end
    end
    exp_q.delete();
  endtask

  task automatic test_idle();
    send_byte(COM);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", valid_out); end
    checks++; if (data_out !== 8'hDD) begin errors++; $display("FAIL idle_hold got=%h exp=dd", data_out); end
    checks++; if (strobe_seen != 1) begin errors++; $display("FAIL idle_strobes got=%0d exp=1", strobe_seen); end
    strobe_seen = 0;
    send_bits(8'hFF, 7);
    checks++; if (valid_out !== 1'b0 || data_out !== 8'hDD) begin errors++; $display("FAIL idle_mid got=%b/%h exp=0/dd", valid_out, data_out); end
    send_bit(1'b1);
    checks++; if (valid_out !== 1'b1 || data_out !== 8'hFF) begin errors++; $display("FAIL idle_ff got=%b/%h exp=1/ff", valid_out, data_out); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 24; n++) begin
      v = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom_range(0, 255));
      send_byte(v);
      checks++;
      if (data_out !== exp_data || valid_out !== exp_valid || strobe_seen != 1 || active !== 1'b1) begin
        errors++;
        $display("FAIL random_sym sym=%h got=%h/%b/%0d/%b exp=%h/%b/1/1",
                 v, data_out, valid_out, strobe_seen, active, exp_data, exp_valid);
      end
    end
  endtask

  task automatic test_junk();
    pulse_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (NCOM) send_byte(COM);
    checks++; if (active !== 1'b1 || exp_active !== 1'b1) begin errors++; $display("FAIL junk_active got=%b exp=1", active); end
    send_byte(8'hAA);
    checks++; if (data_out !== 8'hAA || valid_out !== 1'b1) begin errors++; $display("FAIL junk_data got=%h/%b exp=aa/1", data_out, valid_out); end
  endtask

  task automatic test_false_start();
    pulse_reset();
    repeat (3) send_byte(COM);
    send_byte(8'h12);
    checks++; if (active !== 1'b0 || exp_active !== 1'b0) begin errors++; $display("FAIL false_after12 got=%b exp=0", active); end
    repeat (3) send_byte(COM);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL false_after3 got=%b exp=0", active); end
    send_byte(COM);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL false_after4 got=%b exp=1", active); end
    send_byte(8'h5A);
    checks++; if (data_out !== 8'h5A || valid_out !== exp_valid) begin errors++; $display("FAIL false_data got=%h exp=5a", data_out); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h3C);
    send_bits(8'hEA, 4);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || byte_strobe !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear got=%h/%b/%b/%b exp=00/0/0/0", data_out, valid_out, byte_strobe, active);
    end
    repeat (2) @(posedge clk_32f);
    release_reset();
    valid_seen = 1'b0;
    send_bits(8'hEA, 4);
    repeat (3) send_byte(COM);
    checks++; if (active !== 1'b0 || valid_seen !== 1'b0) begin errors++; $display("FAIL midreset_quiet got=%b/%b exp=0/0", active, valid_seen); end
    send_byte(COM);
    checks++; if (active !== exp_active || active !== 1'b1) begin errors++; $display("FAIL midreset_relock got=%b exp=1", active); end
    send_byte(8'h77);
    checks++; if (data_out !== 8'h77 || valid_out !== 1'b1) begin errors++; $display("FAIL midreset_data got=%h/%b exp=77/1", data_out, valid_out); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_align();
    test_payload();
    test_idle();
    test_random();
    test_junk();
    test_false_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
